traffic_lamp_driver: RTL and testbench



---
 rtl/traffic_lamp_driver.sv | 163 ++++++++++++++++
 tb/tb_traffic_lamp_driver.sv | 129 ++++++++++++
 2 files changed

// File: rtl/traffic_lamp_driver.sv
// Lamp driver for the intersection controller: decodes signal-state codes into
// registered lamp enables, blinks walker twinkle, latches flashing-yellow on sustained conflict.
module traffic_lamp_driver #(
  parameter int BLINK_HALF   = 1,
  parameter int FAULT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] i_h_car_traffic,
  input  logic [2:0] i_h_walker_traffic,
  input  logic [2:0] i_v_car_traffic,
  input  logic [2:0] i_v_walker_traffic,
  input  logic       i_fault_clear,
  output logic [3:0] o_h_car_lamp,
  output logic [3:0] o_v_car_lamp,
  output logic [1:0] o_h_walker_lamp,
  output logic [1:0] o_v_walker_lamp,
  output logic       o_fault
);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int CW = $clog2(FAULT_CYCLES + 1);

  localparam logic [2:0] C_RED = 3'd0, C_GREEN = 3'd1, C_YELLOW = 3'd2,
                         C_LEFT = 3'd3, C_TWINKLE = 3'd4;

  typedef enum logic {NORMAL, FAULT} state_e;

  state_e        state_q, state_d;
  logic [3:0]    h_car_q, h_car_d, v_car_q, v_car_d;
  logic [1:0]    h_walk_q, h_walk_d, v_walk_q, v_walk_d;
  logic          fault_q, fault_d;
  logic [BW-1:0] hw_cnt_q, hw_cnt_d, vw_cnt_q, vw_cnt_d, fl_cnt_q, fl_cnt_d;
  logic          hw_ph_q, hw_ph_d, vw_ph_q, vw_ph_d, fl_ph_q, fl_ph_d;
  logic [CW-1:0] conf_q, conf_d;
  logic [CW:0]   conf_inc;
  logic          conflict;
  logic [BW:0]   hw_nxt, vw_nxt;

  function automatic logic [3:0] car_dec(input logic [2:0] c);
    case (c)
      C_GREEN:  car_dec = 4'b0100;
      C_YELLOW: car_dec = 4'b0010;
      C_LEFT:   car_dec = 4'b1001;
      default:  car_dec = 4'b0001;
    endcase
  endfunction

  function automatic logic [1:0] walk_dec(input logic [2:0] c, input logic ph_off);
    case (c)
      C_GREEN:   walk_dec = 2'b10;
      C_TWINKLE: walk_dec = ph_off ? 2'b00 : 2'b10;
      default:   walk_dec = 2'b01;
    endcase
  endfunction

  function automatic logic walk_go(input logic [2:0] c);
    walk_go = (c == C_GREEN) || (c == C_TWINKLE);
  endfunction

  // Returns {phase, count} after one more cycle in the current phase.
  function automatic logic [BW:0] blink_adv(input logic [BW-1:0] c, input logic ph);
    if (c == BW'(BLINK_HALF - 1)) blink_adv = {~ph, {BW{1'b0}}};
    else                          blink_adv = {ph, c + BW'(1)};
  endfunction

  always_comb begin
    conflict = ((i_h_car_traffic != C_RED) && (i_v_car_traffic != C_RED))
            || (walk_go(i_h_walker_traffic) && (i_h_car_traffic != C_RED))
            || (walk_go(i_v_walker_traffic) && (i_v_car_traffic != C_RED))
            || (i_h_car_traffic > C_TWINKLE) || (i_h_walker_traffic > C_TWINKLE)
            || (i_v_car_traffic > C_TWINKLE) || (i_v_walker_traffic > C_TWINKLE);
    conf_inc = {1'b0, conf_q} + (CW+1)'(1);
    hw_nxt   = (i_h_walker_traffic == C_TWINKLE) ? blink_adv(hw_cnt_q, hw_ph_q) : '0;
    vw_nxt   = (i_v_walker_traffic == C_TWINKLE) ? blink_adv(vw_cnt_q, vw_ph_q) : '0;

    state_d  = state_q;
    fault_d  = fault_q;
    conf_d   = conf_q;
    h_car_d  = car_dec(i_h_car_traffic);
    v_car_d  = car_dec(i_v_car_traffic);
    h_walk_d = walk_dec(i_h_walker_traffic, hw_ph_q);
    v_walk_d = walk_dec(i_v_walker_traffic, vw_ph_q);
    {hw_ph_d, hw_cnt_d} = hw_nxt;
    {vw_ph_d, vw_cnt_d} = vw_nxt;
    fl_ph_d  = 1'b0;
    fl_cnt_d = '0;

    case (state_q)
      NORMAL: begin
        if (!conflict) begin
          conf_d = '0;
        end else begin
          if (conf_inc <= (CW+1)'(FAULT_CYCLES)) conf_d = conf_inc[CW-1:0];
          if (conf_inc >= (CW+1)'(FAULT_CYCLES)) begin
            state_d  = FAULT;
            fault_d  = 1'b1;
            h_car_d  = 4'b0010;
            v_car_d  = 4'b0010;
            h_walk_d = 2'b01;
            v_walk_d = 2'b01;
            {hw_ph_d, hw_cnt_d} = '0;
            {vw_ph_d, vw_cnt_d} = '0;
            {fl_ph_d, fl_cnt_d} = blink_adv('0, 1'b0);
          end
        end
      end
      default: begin
        // Leaving FAULT takes the normal decode computed above.
        if (i_fault_clear && !conflict) begin
          state_d = NORMAL;
          fault_d = 1'b0;
          conf_d  = '0;
        end else begin
          h_car_d  = fl_ph_q ? 4'b0000 : 4'b0010;
          v_car_d  = fl_ph_q ? 4'b0000 : 4'b0010;
          h_walk_d = 2'b01;
          v_walk_d = 2'b01;
          {hw_ph_d, hw_cnt_d} = '0;
          {vw_ph_d, vw_cnt_d} = '0;
          {fl_ph_d, fl_cnt_d} = blink_adv(fl_cnt_q, fl_ph_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= NORMAL;
      fault_q  <= 1'b0;
      conf_q   <= '0;
      h_car_q  <= 4'b0001;
      v_car_q  <= 4'b0001;
      h_walk_q <= 2'b01;
      v_walk_q <= 2'b01;
      hw_cnt_q <= '0;
      hw_ph_q  <= 1'b0;
      vw_cnt_q <= '0;
      vw_ph_q  <= 1'b0;
      fl_cnt_q <= '0;
      fl_ph_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      conf_q   <= conf_d;
      h_car_q  <= h_car_d;
      v_car_q  <= v_car_d;
      h_walk_q <= h_walk_d;
      v_walk_q <= v_walk_d;
      hw_cnt_q <= hw_cnt_d;
      hw_ph_q  <= hw_ph_d;
      vw_cnt_q <= vw_cnt_d;
      vw_ph_q  <= vw_ph_d;
      fl_cnt_q <= fl_cnt_d;
      fl_ph_q  <= fl_ph_d;
    end
  end

  assign o_h_car_lamp    = h_car_q;
  assign o_v_car_lamp    = v_car_q;
  assign o_h_walker_lamp = h_walk_q;
  assign o_v_walker_lamp = v_walk_q;
  assign o_fault         = fault_q;
endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Bench for traffic_lamp_driver: vectors carry inputs plus expected lamps, expectations
// queue up at drive time and are popped and compared one cycle later.
module tb_traffic_lamp_driver;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] hc, hw, vc, vw;
  logic       clr;
  logic [3:0] o_hc, o_vc;
  logic [1:0] o_hw, o_vw;
  logic       o_fault;

  traffic_lamp_driver #(.BLINK_HALF(1), .FAULT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_h_car_traffic(hc), .i_h_walker_traffic(hw),
    .i_v_car_traffic(vc), .i_v_walker_traffic(vw),
    .i_fault_clear(clr),
    .o_h_car_lamp(o_hc), .o_v_car_lamp(o_vc),
    .o_h_walker_lamp(o_hw), .o_v_walker_lamp(o_vw),
    .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] R = 3'd0, G = 3'd1, Y = 3'd2, L = 3'd3, T = 3'd4;

  typedef struct {
    logic       rst_n, clr;
    logic [2:0] hc, hw, vc, vw;
    logic [3:0] ehc, evc;
    logic [1:0] ehw, evw;
    logic       ef;
    string      name;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];
  int   n_cmp = 0, n_bad = 0;

  function automatic vec_t mk(input string nm, input logic rn, input logic cl,
                              input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] c, input logic [2:0] d,
                              input logic [3:0] e0, input logic [3:0] e1,
                              input logic [1:0] e2, input logic [1:0] e3, input logic e4);
    vec_t v;
    v.name = nm; v.rst_n = rn; v.clr = cl;
    v.hc = a; v.hw = b; v.vc = c; v.vw = d;
    v.ehc = e0; v.evc = e1; v.ehw = e2; v.evw = e3; v.ef = e4;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, req);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset_n = v.rst_n; clr = v.clr;
    hc = v.hc; hw = v.hw; vc = v.vc; vw = v.vw;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.name, ".hcar"}, o_hc, e.ehc);
    chk({e.name, ".vcar"}, o_vc, e.evc);
    chk({e.name, ".hwalk"}, {2'b00, o_hw}, {2'b00, e.ehw});
    chk({e.name, ".vwalk"}, {2'b00, o_vw}, {2'b00, e.evw});
    chk({e.name, ".fault"}, {3'b000, o_fault}, {3'b000, e.ef});
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; hc = R; hw = R; vc = R; vw = R;

    // Single-cycle decode table
    tbl.push_back(mk("rst0", 0, 0, G, R, R, G, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    tbl.push_back(mk("rst1", 0, 0, G, R, R, G, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    tbl.push_back(mk("rel",  1, 0, G, R, R, G, 4'b0100, 4'b0001, 2'b01, 2'b10, 0));
    tbl.push_back(mk("hleft",1, 0, L, R, R, R, 4'b1001, 4'b0001, 2'b01, 2'b01, 0));
    tbl.push_back(mk("hyel", 1, 0, Y, R, R, R, 4'b0010, 4'b0001, 2'b01, 2'b01, 0));
    tbl.push_back(mk("hred", 1, 0, R, R, R, R, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    tbl.push_back(mk("vgrn", 1, 0, R, G, G, R, 4'b0001, 4'b0100, 2'b10, 2'b01, 0));
    tbl.push_back(mk("vleft",1, 0, R, Y, L, R, 4'b0001, 4'b1001, 2'b01, 2'b01, 0));
    tbl.push_back(mk("vyel", 1, 1, R, L, Y, R, 4'b0001, 4'b0010, 2'b01, 2'b01, 0));
    tbl.push_back(mk("hwill",1, 0, R, 3'd7, R, R, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    tbl.push_back(mk("vctw", 1, 0, R, R, T, R, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    tbl.push_back(mk("gg1",  1, 0, G, R, G, R, 4'b0100, 4'b0100, 2'b01, 2'b01, 0));
    tbl.push_back(mk("allr", 1, 0, R, R, R, R, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    tbl.push_back(mk("gg1b", 1, 1, G, R, G, R, 4'b0100, 4'b0100, 2'b01, 2'b01, 0));
    tbl.push_back(mk("allr2",1, 0, R, R, R, R, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // v walker twinkle: on/off alternation, restart on re-entry
    for (int i = 0; i < 6; i++)
      step(mk($sformatf("vtw%0d", i), 1, 0, G, R, R, T, 4'b0100, 4'b0001, 2'b01,
              (i % 2 == 0) ? 2'b10 : 2'b00, 0));
    step(mk("vtw_red", 1, 0, R, R, R, R, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    step(mk("vtw_re0", 1, 0, R, R, R, T, 4'b0001, 4'b0001, 2'b01, 2'b10, 0));
    step(mk("vtw_re1", 1, 0, R, T, R, T, 4'b0001, 4'b0001, 2'b10, 2'b00, 0));
    step(mk("htw1",    1, 0, R, T, R, R, 4'b0001, 4'b0001, 2'b00, 2'b01, 0));

    // Sustained car conflict enters FAULT, flashes, then clear rules
    step(mk("f_c1",  1, 0, G, R, G, R, 4'b0100, 4'b0100, 2'b01, 2'b01, 0));
    step(mk("f_c2",  1, 0, G, R, G, R, 4'b0010, 4'b0010, 2'b01, 2'b01, 1));
    step(mk("f_fl1", 1, 0, R, G, R, G, 4'b0000, 4'b0000, 2'b01, 2'b01, 1));
    step(mk("f_fl2", 1, 0, R, R, R, R, 4'b0010, 4'b0010, 2'b01, 2'b01, 1));
    step(mk("f_ill", 1, 1, R, R, 3'd5, R, 4'b0000, 4'b0000, 2'b01, 2'b01, 1));
    step(mk("f_clr", 1, 1, G, R, R, G, 4'b0100, 4'b0001, 2'b01, 2'b10, 0));
    step(mk("f_nrm", 1, 0, R, R, R, R, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));

    // Walker/car conflict re-enters FAULT, reset mid-FAULT
    step(mk("w_c1",  1, 0, Y, G, R, R, 4'b0010, 4'b0001, 2'b10, 2'b01, 0));
    step(mk("w_c2",  1, 0, Y, G, R, R, 4'b0010, 4'b0010, 2'b01, 2'b01, 1));
    step(mk("w_rst", 0, 0, Y, G, R, R, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    step(mk("w_rel", 1, 0, R, R, L, R, 4'b0001, 4'b1001, 2'b01, 2'b01, 0));

    // Illegal code held two cycles is a sustained conflict
    step(mk("i_c1",  1, 0, R, R, R, 3'd5, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));
    step(mk("i_c2",  1, 0, R, R, R, 3'd5, 4'b0010, 4'b0010, 2'b01, 2'b01, 1));
    step(mk("i_hold",1, 0, R, R, R, R, 4'b0000, 4'b0000, 2'b01, 2'b01, 1));
    step(mk("i_clr", 1, 1, R, R, R, R, 4'b0001, 4'b0001, 2'b01, 2'b01, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
